// File: rtl/rv_iopmp_err_queue.sv
// Multi-channel IOPMP error-record queue: round-robin capture of violation
// reports into a first-word-fall-through FIFO with a saturating lost-event counter.
module rv_iopmp_err_queue #(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int RRID_WIDTH = 16,
  parameter int EID_WIDTH  = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_CH-1:0]                          err_valid_i,
  input  logic [NUM_CH*2-1:0]                        err_ttype_i,
  input  logic [NUM_CH*3-1:0]                        err_etype_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]               err_addr_i,
  input  logic [NUM_CH*RRID_WIDTH-1:0]               err_rrid_i,
  input  logic [NUM_CH*EID_WIDTH-1:0]                err_eid_i,
  output logic                                       rec_valid_o,
  output logic [1:0]                                 rec_ttype_o,
  output logic [2:0]                                 rec_etype_o,
  output logic [ADDR_WIDTH-1:0]                      rec_addr_o,
  output logic [RRID_WIDTH-1:0]                      rec_rrid_o,
  output logic [EID_WIDTH-1:0]                       rec_eid_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rec_ch_o,
  input  logic                                       rec_pop_i,
  output logic [$clog2(DEPTH+1)-1:0]                 count_o,
  output logic [DROP_WIDTH-1:0]                      drop_cnt_o,
  input  logic                                       drop_clr_i,
  input  logic                                       irq_en_i,
  output logic                                       irq_o
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int REC_W = 2 + 3 + ADDR_WIDTH + RRID_WIDTH + EID_WIDTH + CH_W;
  localparam int SUM_W = DROP_WIDTH + CH_W + 1;

  logic [REC_W-1:0]      ch_rec [NUM_CH];
  logic [REC_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic [CH_W-1:0]       rr_reg, rr_next, grant;
  logic [DROP_WIDTH-1:0] drop_reg, drop_next;
  logic                  irq_reg, irq_next;
  logic                  any_valid, push, pop;
  logic [SUM_W-1:0]      valid_cnt, drop_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_rec[gi] = {err_ttype_i[gi*2 +: 2], err_etype_i[gi*3 +: 3],
                           err_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH],
                           err_rrid_i[gi*RRID_WIDTH +: RRID_WIDTH],
                           err_eid_i[gi*EID_WIDTH +: EID_WIDTH], CH_W'(gi)};
    end
  endgenerate

  // Scan offsets high to low so the channel nearest rr_reg wins.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    valid_cnt = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (err_valid_i[(int'(rr_reg) + i) % NUM_CH]) begin
        grant     = CH_W'((int'(rr_reg) + i) % NUM_CH);
        any_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      valid_cnt = valid_cnt + SUM_W'(err_valid_i[i]);
    end
  end

  always_comb begin
    pop         = rec_pop_i && (count_reg != '0);
    push        = any_valid && ((count_reg < CNT_W'(DEPTH)) || pop);
    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    rr_next     = rr_reg;
    if (push) begin
      rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
    drop_sum  = SUM_W'(drop_reg) + valid_cnt - SUM_W'(push);
    drop_next = drop_sum[DROP_WIDTH-1:0];
    if (drop_sum > SUM_W'({DROP_WIDTH{1'b1}})) begin
      drop_next = '1;
    end
    if (drop_clr_i) begin
      drop_next = '0;
    end
    irq_next = irq_en_i && ((count_next != '0) || (drop_next != '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rr_reg     <= '0;
      drop_reg   <= '0;
      irq_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      rr_reg     <= rr_next;
      drop_reg   <= drop_next;
      irq_reg    <= irq_next;
    end
  end

  // Storage carries no reset; stale contents are hidden by the valid mask below.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= ch_rec[grant];
    end
  end

  logic [REC_W-1:0] head;
  assign head        = rec_valid_o ? mem[rd_ptr_reg] : '0;
  assign rec_valid_o = (count_reg != '0);
  assign {rec_ttype_o, rec_etype_o, rec_addr_o, rec_rrid_o, rec_eid_o, rec_ch_o} = head;
  assign count_o     = count_reg;
  assign drop_cnt_o  = drop_reg;
  assign irq_o       = irq_reg;
endmodule

// File: doc/rv_iopmp_err_queue.md
# rv_iopmp_err_queue

Multi-channel IOPMP error-record queue that replaces the single-slot, first-error-only capture. It collects violation reports from `NUM_CH` parallel checker channels (e.g. read/write paths, or several IOPMP instances), arbitrates them round-robin into a `DEPTH`-entry FIFO, and presents the oldest record to the register file. Records are retired by a software pop. The block also provides a saturating lost-error counter and a level interrupt, and sits between the IOPMP checkers and the `ERR_*` register block.

## Interface
Parameters:
- `NUM_CH`, 2: number of reporting channels, ≥1.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ADDR_WIDTH`, 64: error address width (maps to `ERR_REQADDR`/`ERR_REQADDRH`).
- `RRID_WIDTH`, 16: requester-ID width.
- `EID_WIDTH`, 16: matching-entry index width.
- `DROP_WIDTH`, 8: lost-error counter width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: asynchronous active-low reset.
- `err_valid_i`, in, NUM_CH: one-cycle error pulse per channel; no backpressure.
- `err_ttype_i`, in, NUM_CH×2: transaction type (01 read, 10 write, 11 exec).
- `err_etype_i`, in, NUM_CH×3: error type code.
- `err_addr_i`, in, NUM_CH×ADDR_WIDTH: faulting address.
- `err_rrid_i`, in, NUM_CH×RRID_WIDTH: requester ID.
- `err_eid_i`, in, NUM_CH×EID_WIDTH: matching entry index.
- `rec_valid_o`, out, 1: head record present.
- `rec_ttype_o`, `rec_etype_o`, `rec_addr_o`, `rec_rrid_o`, `rec_eid_o`, out, as inputs: head record fields.
- `rec_ch_o`, out, max(1,$clog2(NUM_CH)): source channel of the head record.
- `rec_pop_i`, in, 1: retire head record (single-cycle pulse).
- `count_o`, out, $clog2(DEPTH+1): occupied entries.
- `drop_cnt_o`, out, DROP_WIDTH: saturating count of lost error events.
- `drop_clr_i`, in, 1: clear `drop_cnt_o`.
- `irq_en_i`, in, 1: interrupt enable.
- `irq_o`, out, 1: registered interrupt.

## Operation
- Arbitration: a round-robin pointer `rr_q` is reset to 0. The grant goes to the first channel with valid asserted, scanning from `rr_q` upward with wrap.
  - On an accepted push, `rr_q` ← (grant+1) mod NUM_CH.
  - The pointer does not move when nothing is accepted.
- At most one push per cycle. All other valid channels in that cycle are lost.
- Push is accepted iff some valid is asserted AND (`count` < DEPTH OR pop takes effect this cycle).
- Pop takes effect iff `rec_pop_i` && `count` ≠ 0. A pop while empty is ignored.
- FIFO uses wrapping write/read pointers of width $clog2(DEPTH). `count` is updated by +push −pop.
- Full with push and pop in the same cycle: the pop frees the head, the push is accepted, and `count` stays at DEPTH.
- Lost events per cycle = popcount(`err_valid_i`) − accepted (0 or 1). `drop_cnt` adds this amount and saturates at all-ones.
- `drop_clr_i` has priority: the counter becomes 0 and that cycle's losses are discarded.
- `irq_o` next = `irq_en_i` && (`count_next` ≠ 0 || `drop_cnt_next` ≠ 0).
- `rec_*` outputs come straight from the head slot (first-word fall-through). Their value is 0 whenever `rec_valid_o` = 0.

## Timing
- Reset (asynchronous, `rst_ni` low): pointers, `count_o`, `rr_q`, `drop_cnt_o`, `irq_o`, `rec_valid_o` and all `rec_*` outputs go to 0. Contents are discarded, and any pulse in flight is lost without being counted.
- Push latency: a pulse in cycle N appears at the head (when the queue was empty) with `rec_valid_o` = 1 in cycle N+1.
- Pop: asserted in cycle N, the next record (or `rec_valid_o` = 0) is visible in cycle N+1.
- `count_o`, `drop_cnt_o` and `irq_o` all update on the same edge as the push/pop/clear that caused the change.
- No combinational path from `err_valid_i` or `rec_pop_i` to any output.

## Test plan
- Single event: ch1 pulses with addr=0x8000_1000, etype=3, rrid=5, eid=7.
  - Next cycle: `rec_valid_o` = 1, fields match, `rec_ch_o` = 1, `count_o` = 1.
  - With `irq_en_i` = 1, `irq_o` = 1.
  - After pop: `count_o` = 0 and `irq_o` = 0.
- Simultaneous events: ch0 and ch1 pulse together for 3 consecutive cycles, starting from `rr_q` = 0.
  - Accepted order is ch0, ch1, ch0.
  - `drop_cnt_o` = 3 and `count_o` = 3.
- Fill and overflow with DEPTH=4: 4 single pulses give `count_o` = 4.
  - A 5th pulse (no pop) is lost: `drop_cnt_o` increments by 1 and the head is unchanged.
  - Full plus pop plus push in one cycle: `count_o` stays 4 and the new record lands at the tail.
- Saturation and clear with DROP_WIDTH=2: 5 lost events give `drop_cnt_o` = 3.
  - `drop_clr_i` together with a lost event gives `drop_cnt_o` = 0.
- Pointer wrap: push/pop 10 records one at a time with distinct addresses 0..9. Each head address matches in order.
- Reset mid-operation: assert `rst_ni` = 0 with `count_o` = 3 and `drop_cnt_o` = 2.
  - All outputs go to 0 immediately.
  - The first pulse after release is accepted from ch0 priority.
